and2_pipe_stage: RTL and testbench

//   Registered, flow-controlled stage around a WIDTH-bit bank of and2 cells: accepts operand

---
 rtl/and2_pipe_stage.sv | 121 ++++++++++++
 tb/tb_and2_pipe_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/and2_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : and2_pipe_stage
// Purpose  : Registered 2-entry skid stage for a WIDTH-bit and2 bank, with
//            head popcount and a wrapping output-transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
module and2_pipe_stage #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8,
  parameter int POP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [POP_W-1:0] out_ones,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic [WIDTH-1:0] and_w;
  logic             push_w;
  logic             pop_w;

  assign and_w  = in_a & in_b;
  assign push_w = in_valid & in_ready;
  assign pop_w  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push_w) state_d = S_ONE;
      S_ONE: begin
        if (push_w && !pop_w)      state_d = S_FULL;
        else if (!push_w && pop_w) state_d = S_EMPTY;
      end
      S_FULL:  if (pop_w) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // Ready/valid depend only on state (and reset), never on the partner handshake.
  always_comb begin
    in_ready  = rst_n & (state_q != S_FULL);
    out_valid = (state_q != S_EMPTY);
  end

  // Entries are cleared when vacated so an empty stage always presents zero.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      S_EMPTY: if (push_w) head_d = and_w;
      S_ONE: begin
        if (push_w)     head_d = pop_w ? and_w : head_q;
        if (push_w && !pop_w) tail_d = and_w;
        if (!push_w && pop_w) head_d = '0;
      end
      S_FULL: begin
        if (pop_w) begin
          head_d = tail_q;
          tail_d = '0;
        end
      end
      default: begin
        head_d = '0;
        tail_d = '0;
      end
    endcase
  end

  always_comb begin
    xfer_d = xfer_q;
    if (pop_w) xfer_d = xfer_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      xfer_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      xfer_q <= xfer_d;
    end
  end

  always_comb begin
    out_c    = out_valid ? head_q : '0;
    out_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_ones = out_ones + POP_W'(out_c[i]);
    end
  end

  assign xfer_count = xfer_q;

endmodule
`default_nettype wire

// File: tb/tb_and2_pipe_stage.sv
`default_nettype none
// Directed and randomised checks of and2_pipe_stage against a queue-based
// reference model, plus literal expectations at key points.
module tb_and2_pipe_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_a;
  logic [4:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_c;
  logic [2:0] out_ones;
  logic [7:0] xfer_count;

  int n_pass  = 0;
  int n_total = 0;

  and2_pipe_stage #(.WIDTH(5), .CNT_W(8), .POP_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_c      (out_c),
    .out_ones   (out_ones),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a 2-deep FIFO of results and a transfer tally.
  logic [4:0] mq[$];
  int         mcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      automatic bit do_push = in_valid && (mq.size() < 2);
      automatic bit do_pop  = (mq.size() > 0) && out_ready;
      if (do_pop) begin
        void'(mq.pop_front());
        mcnt = (mcnt + 1) % 256;
      end
      if (do_push) mq.push_back(in_a & in_b);
    end
  end

  always @(negedge clk) begin
    automatic logic [4:0] exp_c = (mq.size() > 0) ? mq[0] : 5'd0;
    check("m_out_valid",  {31'd0, out_valid}, {31'd0, mq.size() > 0});
    check("m_out_c",      {27'd0, out_c},     {27'd0, exp_c});
    check("m_out_ones",   {29'd0, out_ones},  $countones(exp_c));
    check("m_in_ready",   {31'd0, in_ready},  {31'd0, rst_n && (mq.size() < 2)});
    check("m_xfer_count", {24'd0, xfer_count}, mcnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready",  {31'd0, in_ready}, 0);
    check("rst_xfer",      {24'd0, xfer_count}, 0);
    step(); step();
    rst_n = 1'b1;

    // Single pass
    in_valid = 1'b1; in_a = 5'b10110; in_b = 5'b11100; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_valid", {31'd0, out_valid}, 1);
    check("single_c",     {27'd0, out_c}, 32'b10100);
    check("single_ones",  {29'd0, out_ones}, 2);
    check("single_xfer0", {24'd0, xfer_count}, 0);
    step();
    check("single_xfer1", {24'd0, xfer_count}, 1);
    check("single_empty", {31'd0, out_valid}, 0);

    // Fill and stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 5'b11111; in_b = 5'b11111;
    step();
    in_a = 5'b00001; in_b = 5'b00001;
    step();
    check("fill_full_ready", {31'd0, in_ready}, 0);
    in_a = 5'b01010; in_b = 5'b01110;
    step();
    check("fill_hold_c",     {27'd0, out_c}, 32'b11111);
    check("fill_hold_ones",  {29'd0, out_ones}, 5);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("drain_c1",     {27'd0, out_c}, 32'b00001);
    check("drain_ready",  {31'd0, in_ready}, 1);
    step();
    check("drain_empty",  {31'd0, out_valid}, 0);
    check("drain_xfer",   {24'd0, xfer_count}, 3);

    // Streaming push&pop while holding one entry
    in_valid = 1'b1; in_b = 5'b11111; in_a = 5'd0;
    step();
    for (int i = 1; i <= 10; i++) begin
      in_a = 5'(i);
      step();
      check("stream_c",     {27'd0, out_c}, i);
      check("stream_ready", {31'd0, in_ready}, 1);
      check("stream_xfer",  {24'd0, xfer_count}, 3 + i);
    end
    in_valid = 1'b0;
    step();

    // Counter wrap from a fresh reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; in_a = 5'b00011; in_b = 5'b00110;
    for (int i = 0; i < 257; i++) step();
    check("wrap_zero", {24'd0, xfer_count}, 0);
    step();
    check("wrap_one",  {24'd0, xfer_count}, 1);
    in_valid = 1'b0;
    step();
    check("wrap_two",  {24'd0, xfer_count}, 2);

    // Random valid/ready with upstream holding data until accepted
    in_valid = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      acc = in_valid && in_ready;
      if (acc || !in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a     = 5'($urandom);
        in_b     = 5'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    check("rand_drained", {31'd0, out_valid}, 0);

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 5'b11011; in_b = 5'b10011;
    step(); step();
    in_valid = 1'b0;
    check("pre_rst_full", {31'd0, in_ready}, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 0);
    check("arst_c",     {27'd0, out_c}, 0);
    check("arst_ones",  {29'd0, out_ones}, 0);
    check("arst_ready", {31'd0, in_ready}, 0);
    check("arst_xfer",  {24'd0, xfer_count}, 0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_a = 5'b00111; in_b = 5'b01111;
    #1;
    check("rel_ready", {31'd0, in_ready}, 1);
    step();
    in_valid = 1'b0;
    check("rel_first_valid", {31'd0, out_valid}, 1);
    check("rel_first_c",     {27'd0, out_c}, 32'b00111);
    out_ready = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
